// File: rtl/scaler_stream_arbiter_if.sv
// rtl/scaler_stream_arbiter_if.sv - stream bundle shared by two line requesters, the arbiter and the scaler relay
//
// Purpose : groups every handshake/payload signal of scaler_stream_arbiter so the
//           arbiter and its environment connect through one port.
// Modports: master - arbiter view (consumes s0/s1 streams, drives m stream, m_sel, busy)
//           slave  - environment view (drives s0/s1 streams and m_ready, observes the rest)
// Signals : s0_valid/s0_data/s0_last/s0_ready - requester 0 stream, last ends a line
//           s1_valid/s1_data/s1_last/s1_ready - requester 1 stream, same meaning
//           m_valid/m_data/m_last/m_ready     - shared stream toward the scaler relay
//           m_sel                             - source index of the beat on m_data
//           busy                              - a line grant is currently held

interface scaler_stream_arbiter_if #(
  parameter int C_DATA_WIDTH = 12
);

  logic                    s0_valid;
  logic [C_DATA_WIDTH-1:0] s0_data;
  logic                    s0_last;
  logic                    s0_ready;

  logic                    s1_valid;
  logic [C_DATA_WIDTH-1:0] s1_data;
  logic                    s1_last;
  logic                    s1_ready;

  logic                    m_valid;
  logic [C_DATA_WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_ready;
  logic                    m_sel;

  logic                    busy;

  modport master (
    input  s0_valid, s0_data, s0_last,
    output s0_ready,
    input  s1_valid, s1_data, s1_last,
    output s1_ready,
    output m_valid, m_data, m_last, m_sel,
    input  m_ready,
    output busy
  );

  modport slave (
    output s0_valid, s0_data, s0_last,
    input  s0_ready,
    output s1_valid, s1_data, s1_last,
    input  s1_ready,
    input  m_valid, m_data, m_last, m_sel,
    output m_ready,
    input  busy
  );

endinterface

// File: rtl/scaler_stream_arbiter.sv
// rtl/scaler_stream_arbiter.sv - line-granular two-way stream arbiter feeding the scaler relay
//
// Purpose : shares one registered output stream between two line-based requesters.
//           A grant covers a whole line (up to and including the beat with last set);
//           arbitration takes one cycle in IDLE, so consecutive lines are separated by
//           exactly one bubble. Inside a line the output register sustains one beat
//           per cycle when it drains and refills on the same edge.
// Ports   : clk    - single clock, rising edge
//           resetn - asynchronous active-low reset
//           bus    - scaler_stream_arbiter_if.master (s0/s1 request streams, m stream,
//                    m_sel, busy)
// Config  : SCALER_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins in IDLE;
//           when undefined, round-robin on a last-served pointer (reset value 1, so
//           requester 0 wins the first contest).

module scaler_stream_arbiter #(
  parameter int C_DATA_WIDTH = 12
) (
  input logic                     clk,
  input logic                     resetn,
  scaler_stream_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  logic [1:0]              state;

  logic                    out_valid;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic                    out_last;
  logic                    out_sel;

  logic                    out_free;
  logic                    s0_ready_i;
  logic                    s1_ready_i;
  logic                    acc0;
  logic                    acc1;
  logic                    acc_any;
  logic [C_DATA_WIDTH-1:0] acc_data;
  logic                    acc_last;
  logic                    any_req;
  logic                    grant_1;

  // The output register can take a new beat when it is empty or being drained
  // this very cycle; that is what keeps a line gap-free under full throughput.
  assign out_free   = ~out_valid | bus.m_ready;

  assign s0_ready_i = (state == ST_GNT0) & out_free;
  assign s1_ready_i = (state == ST_GNT1) & out_free;

  assign acc0       = bus.s0_valid & s0_ready_i;
  assign acc1       = bus.s1_valid & s1_ready_i;
  assign acc_any    = acc0 | acc1;

  // Only one requester can be granted, so a plain select on acc1 is enough.
  assign acc_data   = acc1 ? bus.s1_data : bus.s0_data;
  assign acc_last   = acc1 ? bus.s1_last : bus.s0_last;

  assign any_req    = bus.s0_valid | bus.s1_valid;

`ifdef SCALER_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  assign grant_1 = ~bus.s0_valid;
`else
  // Round-robin: last_served = 1 means requester 1 had the previous line.
  logic last_served;

  assign grant_1 = (bus.s0_valid & bus.s1_valid) ? ~last_served : bus.s1_valid;

  // The pointer only moves when a grant is actually issued, so idle cycles
  // never disturb fairness.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_served <= 1'b1;
    end else if ((state == ST_IDLE) && any_req) begin
      last_served <= grant_1;
    end
  end
`endif

  // Line-level grant FSM. No beat is accepted in IDLE; leaving a grant happens
  // on the edge that accepts the granted requester's last beat. A requester that
  // drops valid mid-line keeps its grant indefinitely.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= grant_1 ? ST_GNT1 : ST_GNT0;
          end
        end
        ST_GNT0: begin
          if (acc0 && bus.s0_last) begin
            state <= ST_IDLE;
          end
        end
        ST_GNT1: begin
          if (acc1 && bus.s1_last) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered output stage. Payload and source tag only load on acceptance,
  // so they stay frozen while the relay stalls; valid clears once the held
  // beat is taken and nothing replaces it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (acc_any) begin
      out_valid <= 1'b1;
      out_data  <= acc_data;
      out_last  <= acc_last;
      out_sel   <= acc1;
    end else if (bus.m_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.s0_ready = s0_ready_i;
  assign bus.s1_ready = s1_ready_i;
  assign bus.m_valid  = out_valid;
  assign bus.m_data   = out_data;
  assign bus.m_last   = out_last;
  assign bus.m_sel    = out_sel;
  assign bus.busy     = (state != ST_IDLE);

endmodule

// File: doc/scaler_stream_arbiter.md
SCALER_STREAM_ARBITER -- requirements
Module: scaler_stream_arbiter

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 12, the payload width of every stream port.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports s0_valid input 1, s0_data input C_DATA_WIDTH, s0_last input 1, s0_ready output 1  requester 0 stream; last marks the final beat of a line.
REQ-005 SHALL have ports s1_valid input 1, s1_data input C_DATA_WIDTH, s1_last input 1, s1_ready output 1  requester 1 stream, same meaning.
REQ-006 SHALL have ports m_valid output 1, m_data output C_DATA_WIDTH, m_last output 1, m_ready input 1  shared stream toward the scaler relay.
REQ-007 SHALL have port m_sel  output  1  source index of the beat currently on m_data.
REQ-008 SHALL have port busy  output  1  high while a line grant is held (state not IDLE).

Function
REQ-009 SHALL share one output stream between two line-based requesters; arbitration granularity is one whole line (s*_last terminated), never a single beat.
REQ-010 SHALL implement states IDLE, GNT0, GNT1.
REQ-011 IDLE: if any s*_valid is high, SHALL select a winner and move to GNT0/GNT1 on the next edge; no beat is accepted in IDLE (one-cycle arbitration latency).
REQ-012 Round-robin: with both valid in IDLE, SHALL grant the requester not served last; with only one valid, SHALL grant that one regardless of history.
REQ-013 Last-served pointer SHALL update only when a grant is issued; after reset it indicates requester 1, so requester 0 wins the first contest.
REQ-014 In GNTn, sn_ready SHALL equal (~m_valid | m_ready); the non-granted s*_ready SHALL be 0; in IDLE both s*_ready SHALL be 0.
REQ-015 A beat is accepted when sn_valid & sn_ready; it SHALL appear on m_valid/m_data/m_last/m_sel on the next cycle (one-cycle registered latency, output stage registered).
REQ-016 Output register SHALL hold its contents while m_valid & ~m_ready; m_data/m_last/m_sel SHALL not change while m_valid is high and m_ready low.
REQ-017 m_valid SHALL drop to 0 on the edge where m_ready is high and no new beat is accepted the same cycle.
REQ-018 Acceptance of a beat with sn_last=1 SHALL return the FSM to IDLE on the same edge; a new grant is therefore issued at earliest one cycle later (exactly one bubble between lines).
REQ-019 Simultaneous output drain and input accept SHALL sustain one beat per cycle with no bubble inside a line.
REQ-020 A granted requester deasserting valid mid-line SHALL keep the grant; no timeout exists.
REQ-021 Single-beat lines (valid and last together on first beat) SHALL be legal and return to IDLE after one accepted beat.

Reset
REQ-022 On resetn=0, asynchronously: state IDLE, m_valid 0, m_data 0, m_last 0, m_sel 0, s0_ready 0, s1_ready 0, busy 0, last-served pointer 1.
REQ-023 Reset mid-line SHALL discard the line without emitting m_last; after release the arbiter starts from IDLE with the reset pointer.

Configuration
REQ-024 Macro SCALER_ARB_FIXED_PRIO_EN: when defined, SHALL grant requester 0 whenever s0_valid is high in IDLE (fixed priority, pointer unused); when undefined, SHALL use the round-robin of REQ-012/013.
REQ-025 Line-level grant hold (REQ-009, REQ-020) SHALL apply in both configurations.

Verification
REQ-026 Both requesters valid continuously with 4-beat lines, m_ready=1 -> output order s0 line, bubble, s1 line, bubble, s0 line; m_sel 0,1,0; 4 beats per line back-to-back.
REQ-027 Only s1 valid with 3-beat line after reset -> grant GNT1 despite pointer, data D0..D2 on m_data at cycles t+2..t+4 relative to first s1_valid, m_last on D2.
REQ-028 m_ready held 0 for 5 cycles mid-line -> m_data frozen, granted s*_ready 0 after output fills, no beat lost or duplicated when m_ready returns.
REQ-029 resetn pulsed low during beat 2 of an 8-beat s0 line -> all outputs 0 immediately, no m_last emitted, next line restarts from IDLE granting s0 first.
REQ-030 SCALER_ARB_FIXED_PRIO_EN defined, both valid continuously -> s1 never granted; undefined, same stimulus -> alternation per REQ-026.
